// File: rtl/eth_img_pkt_arb.sv
// Round-robin UDP image packetizer: arbitrates NUM_CH camera FIFOs and streams
// a two-word header plus PKT_WORDS payload words per packet into the UDP TX core.
module eth_img_pkt_arb #(
   parameter int          NUM_CH      = 2,
   parameter int          PKT_WORDS   = 256,
   parameter int          GAP_CYCLES  = 800,
   parameter int          CNT_W       = 11,
   parameter logic [15:0] FRAME_MAGIC = 16'hF05A
) (
   input  logic                    eth_tx_clk,
   input  logic                    rst,
   input  logic                    transfer_flag,
   input  logic [NUM_CH-1:0]       ch_vsync,
   input  logic [NUM_CH*CNT_W-1:0] ch_rdusedw,
   input  logic [NUM_CH*32-1:0]    ch_rd_data,
   output logic [NUM_CH-1:0]       ch_rd_en,
   input  logic                    udp_tx_req,
   input  logic                    udp_tx_done,
   output logic                    udp_tx_start_en,
   output logic [15:0]             udp_tx_byte_num,
   output logic [31:0]             udp_tx_data,
   output logic [7:0]              cur_ch
);

   localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int               WC_W     = $clog2(PKT_WORDS + 3);
   localparam int               GC_W     = $clog2(GAP_CYCLES + 1);
   localparam logic [WC_W-1:0]  WC_SAT   = WC_W'(PKT_WORDS + 2);
   localparam logic [WC_W-1:0]  WC_PLAST = WC_W'(PKT_WORDS + 1);
   localparam logic [GC_W-1:0]  GAP_LAST = GC_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W:0]   THRESH   = (CNT_W + 1)'(PKT_WORDS);
   localparam logic [15:0]      BYTE_NUM = 16'((PKT_WORDS + 2) * 4);

   typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_SEND, S_GAP} state_t;

   state_t                   state_q;
   logic [NUM_CH-1:0]        vs_q, sof_q, vs_fall;
   logic [NUM_CH-1:0][15:0]  frame_q, pkt_q;
   logic [CH_W-1:0]          rr_q, sel_q, pick_d, rr_d;
   logic                     hit_d, arb_take, rd_win;
   logic [31:0]              hdr0_q, hdr1_q, data_q;
   logic                     pay_q, start_q;
   logic [15:0]              bnum_q;
   logic [7:0]               cur_ch_q;
   logic [WC_W-1:0]          wcnt_q;
   logic [GC_W-1:0]          gap_q;
   int                       idx;

   // First channel at or after rr_q (with wrap) holding a full packet.
   always_comb begin
      hit_d  = 1'b0;
      pick_d = '0;
      idx    = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!hit_d && ({1'b0, ch_rdusedw[idx*CNT_W +: CNT_W]} >= THRESH)) begin
            hit_d  = 1'b1;
            pick_d = CH_W'(idx);
         end
      end
   end

   assign rr_d     = (int'(pick_d) == NUM_CH - 1) ? '0 : pick_d + CH_W'(1);
   assign arb_take = (state_q == S_ARB) && transfer_flag && hit_d;
   assign vs_fall  = vs_q & ~ch_vsync;
   assign rd_win   = (state_q == S_SEND) && udp_tx_req &&
                     (wcnt_q >= WC_W'(2)) && (wcnt_q <= WC_PLAST);

   // Read strobe is combinational so it goes with the request in the same cycle;
   // gating with rst drops it without waiting for an edge.
   always_comb begin
      ch_rd_en = '0;
      if (!rst) ch_rd_en[sel_q] = rd_win;
   end

   // A vsync fall wins over a same-cycle grant so the new frame still gets SOF.
   always_ff @(posedge eth_tx_clk or posedge rst) begin
      if (rst) begin
         vs_q    <= '0;
         sof_q   <= '0;
         frame_q <= '0;
         pkt_q   <= '0;
      end else begin
         vs_q <= ch_vsync;
         for (int c = 0; c < NUM_CH; c++) begin
            if (vs_fall[c]) begin
               sof_q[c]   <= 1'b1;
               frame_q[c] <= frame_q[c] + 16'd1;
               pkt_q[c]   <= '0;
            end else if (arb_take && (int'(pick_d) == c)) begin
               sof_q[c] <= 1'b0;
               pkt_q[c] <= pkt_q[c] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge eth_tx_clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_q     <= '0;
         sel_q    <= '0;
         hdr0_q   <= '0;
         hdr1_q   <= '0;
         data_q   <= '0;
         pay_q    <= 1'b0;
         start_q  <= 1'b0;
         bnum_q   <= '0;
         cur_ch_q <= '0;
         wcnt_q   <= '0;
         gap_q    <= '0;
      end else begin
         start_q <= 1'b0;
         data_q  <= '0;
         pay_q   <= rd_win;
         case (state_q)
            S_IDLE: if (transfer_flag) state_q <= S_ARB;
            S_ARB: begin
               if (!transfer_flag) begin
                  state_q <= S_IDLE;
               end else if (hit_d) begin
                  sel_q    <= pick_d;
                  cur_ch_q <= 8'(pick_d);
                  hdr0_q   <= {FRAME_MAGIC, sof_q[pick_d], 7'b0, 8'(pick_d)};
                  hdr1_q   <= {frame_q[pick_d], pkt_q[pick_d]};
                  rr_q     <= rr_d;
                  start_q  <= 1'b1;
                  bnum_q   <= BYTE_NUM;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               wcnt_q  <= '0;
               state_q <= S_SEND;
            end
            S_SEND: begin
               if (udp_tx_req) begin
                  if (wcnt_q == WC_W'(0))      data_q <= hdr0_q;
                  else if (wcnt_q == WC_W'(1)) data_q <= hdr1_q;
                  if (wcnt_q != WC_SAT) wcnt_q <= wcnt_q + WC_W'(1);
               end
               if (udp_tx_done) begin
                  gap_q   <= '0;
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_q == GAP_LAST) state_q <= transfer_flag ? S_ARB : S_IDLE;
               else                   gap_q   <= gap_q + GC_W'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Payload words come straight from the FIFO's registered read port so they
   // land one cycle after the request; header words come from data_q.
   assign udp_tx_data     = pay_q ? ch_rd_data[32*sel_q +: 32] : data_q;
   assign udp_tx_start_en = start_q;
   assign udp_tx_byte_num = bnum_q;
   assign cur_ch          = cur_ch_q;

endmodule

// File: tb/tb_eth_img_pkt_arb.sv
// Bench for eth_img_pkt_arb: directed vector table, corner-case sequences and
// randomized packets checked against a packet-level reference model.
module tb_eth_img_pkt_arb;
   localparam int NUM_CH = 2, PKT = 4, GAP = 12, CNT_W = 11;
   localparam int NW = PKT + 2;

   logic                    clk = 1'b0;
   logic                    rst, flag, req, done;
   logic [NUM_CH-1:0]       vsync, rd_en;
   logic [NUM_CH*CNT_W-1:0] used;
   logic [NUM_CH*32-1:0]    rdd = '0;
   logic                    start;
   logic [15:0]             bnum;
   logic [31:0]             data;
   logic [7:0]              cur;

   int errs = 0, checks = 0, cyc = 0, last_done = -1;
   int fseq[NUM_CH] = '{default: 0};
   int exp_seq[NUM_CH] = '{default: 0};
   int m_frame[NUM_CH], m_pkt[NUM_CH], m_rr;
   bit m_sof[NUM_CH];

   always #5 clk = ~clk;

   eth_img_pkt_arb #(.NUM_CH(NUM_CH), .PKT_WORDS(PKT), .GAP_CYCLES(GAP),
                     .CNT_W(CNT_W), .FRAME_MAGIC(16'hF05A)) dut (
      .eth_tx_clk(clk), .rst(rst), .transfer_flag(flag), .ch_vsync(vsync),
      .ch_rdusedw(used), .ch_rd_data(rdd), .ch_rd_en(rd_en), .udp_tx_req(req),
      .udp_tx_done(done), .udp_tx_start_en(start), .udp_tx_byte_num(bnum),
      .udp_tx_data(data), .cur_ch(cur));

   function automatic logic [31:0] fdata(int c, int n);
      return {4'hC, 4'(c), 8'h00, 16'(n)};
   endfunction

   // Camera FIFOs with a registered read port.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int c = 0; c < NUM_CH; c++)
         if (rd_en[c]) begin
            rdd[c*32 +: 32] <= fdata(c, fseq[c]);
            fseq[c]         <= fseq[c] + 1;
         end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %08h want %08h", name, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_start"}, 32'(start), 0);
      chk({tag, "_bnum"}, 32'(bnum), 0);
      chk({tag, "_data"}, data, 0);
      chk({tag, "_cur"}, 32'(cur), 0);
      chk({tag, "_rden"}, 32'(rd_en), 0);
   endtask

   task automatic set_used(input int u0, input int u1);
      used = {CNT_W'(u1), CNT_W'(u0)};
   endtask

   task automatic vs_pulse(input int c);
      vsync[c] = 1'b0; tick();
      vsync[c] = 1'b1; tick();
   endtask

   function automatic int m_pick(int u0, int u1);
      int u[NUM_CH];
      u[0] = u0; u[1] = u1;
      for (int k = 0; k < NUM_CH; k++)
         if (u[(m_rr + k) % NUM_CH] >= PKT) return (m_rr + k) % NUM_CH;
      return -1;
   endfunction

   // Waits for a start pulse, clocks one packet out, checks it and ends with done.
   task automatic run_pkt(input int ch, input logic [31:0] h0, input logic [31:0] h1,
                          input int extra, input int gapmax, input int drop_at,
                          input int vs_at, output int st_cyc);
      logic [31:0] w [0:NW+3];
      int n, rdc, bad, g;
      n = 0; rdc = 0; bad = 0; st_cyc = cyc;
      while (!start && n < 300) begin tick(); n++; end
      chk("start_seen", 32'(start), 1);
      if (!start) return;
      st_cyc = cyc;
      chk("byte_num", 32'(bnum), 24);
      chk("cur_ch", 32'(cur), 32'(ch));
      if (last_done >= 0) begin
         chk("gap_min", 32'(st_cyc - last_done >= GAP), 1);
         chk("gap_max", 32'(st_cyc - last_done <= GAP + 3), 1);
      end
      tick();
      for (int i = 0; i < NW + extra; i++) begin
         g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         repeat (g) begin
            req = 1'b0; #1;
            if (rd_en != '0) bad++;
            tick();
         end
         if (i == drop_at) flag = 1'b0;
         if (i == vs_at) vsync[ch] = 1'b0;
         if (i == vs_at + 1) vsync[ch] = 1'b1;
         req = 1'b1; #1;
         if (rd_en[ch]) rdc++;
         if ((rd_en & ~(NUM_CH'(1) << ch)) != '0) bad++;
         tick();
         w[i] = data;
      end
      req = 1'b0; vsync = '1;
      tick();
      chk("idle_data", data, 0);
      chk("hdr0", w[0], h0);
      chk("hdr1", w[1], h1);
      for (int k = 0; k < PKT; k++) chk("payload", w[2+k], fdata(ch, exp_seq[ch] + k));
      for (int e = 0; e < extra; e++) chk("extra_data", w[NW+e], 0);
      exp_seq[ch] += PKT;
      chk("rd_en_cnt", 32'(rdc), 32'(PKT));
      chk("rd_en_stray", 32'(bad), 0);
      done = 1'b1; last_done = cyc; tick(); done = 1'b0;
   endtask

   typedef struct {
      int u0, u1, vs, ch, extra;
      logic [31:0] h0, h1;
   } vec_t;

   initial begin
      vec_t tv[6];
      int st, rc, cnt, c, u0, u1, vs;
      logic [31:0] h0, h1;
      tv[0] = '{4, 0,  0, 0, 0, 32'hF05A8000, 32'h00010000};
      tv[1] = '{8, 8, -1, 1, 0, 32'hF05A0001, 32'h00000000};
      tv[2] = '{8, 8, -1, 0, 0, 32'hF05A0000, 32'h00010001};
      tv[3] = '{8, 8, -1, 1, 0, 32'hF05A0001, 32'h00000001};
      tv[4] = '{0, 8,  1, 1, 2, 32'hF05A8001, 32'h00010000};
      tv[5] = '{8, 8, -1, 0, 0, 32'hF05A0000, 32'h00010002};

      rst = 1'b1; flag = 1'b0; vsync = '1; used = '0; req = 1'b0; done = 1'b0;
      tick(); tick(); tick();
      chk_zero("reset");
      rst = 1'b0; tick();
      flag = 1'b1; tick();

      foreach (tv[i]) begin
         set_used(0, 0); tick();
         if (tv[i].vs >= 0) vs_pulse(tv[i].vs);
         set_used(tv[i].u0, tv[i].u1);
         run_pkt(tv[i].ch, tv[i].h0, tv[i].h1, tv[i].extra, 0, -1, -1, st);
      end

      // Below-threshold channel never starts; reaching the threshold does.
      set_used(0, 3); cnt = 0;
      repeat (100) begin tick(); if (start) cnt++; end
      chk("no_start_below_thr", 32'(cnt), 0);
      set_used(0, 4); rc = cyc; last_done = -1;
      run_pkt(1, 32'hF05A0001, 32'h00010001, 0, 0, -1, -1, st);
      chk("start_latency", 32'(st - rc <= 3), 1);

      // transfer_flag dropped mid-packet: packet completes, then no more starts.
      set_used(8, 8);
      run_pkt(0, 32'hF05A0000, 32'h00010003, 0, 0, 3, -1, st);
      cnt = 0;
      repeat (GAP + 40) begin tick(); if (start) cnt++; end
      chk("no_start_after_drop", 32'(cnt), 0);
      chk("cur_ch_hold", 32'(cur), 0);

      // vsync fall during a ch0 packet only affects the following ch0 header.
      set_used(8, 0); flag = 1'b1; last_done = -1;
      run_pkt(0, 32'hF05A0000, 32'h00010004, 0, 0, -1, 0, st);
      set_used(0, 0); tick(); set_used(8, 0);
      run_pkt(0, 32'hF05A8000, 32'h00020000, 0, 0, -1, -1, st);

      // Reset in the middle of payload word 3.
      set_used(0, 0); tick(); set_used(8, 8);
      cnt = 0;
      while (!start && cnt < 300) begin tick(); cnt++; end
      chk("rst_seq_start", 32'(start), 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         req = 1'b1; tick();
         if (i == 0) chk("rst_seq_hdr0", data, 32'hF05A0001);
      end
      req = 1'b1; #1;
      chk("rd_en_word3", 32'(rd_en), 32'h2);
      rst = 1'b1; #1;
      chk_zero("rst_async");
      req = 1'b0; tick();
      chk_zero("rst_held");
      exp_seq[1] += 1;
      rst = 1'b0; last_done = -1; tick();
      run_pkt(0, 32'hF05A0000, 32'h00000000, 0, 0, -1, -1, st);

      // Randomized packets against the reference model.
      set_used(0, 0); rst = 1'b1; tick(); rst = 1'b0; tick();
      for (int i = 0; i < NUM_CH; i++) begin m_frame[i] = 0; m_pkt[i] = 0; m_sof[i] = 0; end
      m_rr = 0; last_done = -1;
      for (int it = 0; it < 25; it++) begin
         set_used(0, 0);
         if ($urandom_range(0, 3) == 0) begin
            c = int'($urandom_range(0, NUM_CH - 1));
            vs_pulse(c);
            m_frame[c] = (m_frame[c] + 1) & 16'hFFFF; m_pkt[c] = 0; m_sof[c] = 1'b1;
         end
         u0 = int'($urandom_range(0, 10)); u1 = int'($urandom_range(0, 10));
         if (u0 < PKT && u1 < PKT) begin
            if ($urandom_range(0, 1) == 1) u0 = PKT;
            else u1 = PKT + int'($urandom_range(0, 3));
         end
         c  = m_pick(u0, u1);
         h0 = {16'hF05A, m_sof[c], 7'b0, 8'(c)};
         h1 = {16'(m_frame[c]), 16'(m_pkt[c])};
         m_sof[c] = 1'b0; m_pkt[c] = (m_pkt[c] + 1) & 16'hFFFF; m_rr = (c + 1) % NUM_CH;
         vs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : -1;
         set_used(u0, u1);
         run_pkt(c, h0, h1, int'($urandom_range(0, 2)), 2, -1, vs, st);
         if (vs >= 0) begin
            m_frame[c] = (m_frame[c] + 1) & 16'hFFFF; m_pkt[c] = 0; m_sof[c] = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d of %0d checks", errs, checks);
      $fatal(1);
   end
endmodule

// File: doc/eth_img_pkt_arb.md
Name: eth_img_pkt_arb

Overview:
Parametrised multi-channel UDP image packetizer for the dual-camera Ethernet path. It sits in the eth_tx_clk domain between NUM_CH per-channel image FIFOs and the UDP TX core. Each packet carries a two-word header (magic, channel, SOF flag, frame count, packet count) followed by PKT_WORDS payload words. Channels are served round-robin, with a programmable inter-packet gap.

Parameters:
NUM_CH, 2, number of camera channels (1..8)
PKT_WORDS, 256, payload 32-bit words per packet (1..1024)
GAP_CYCLES, 800, idle cycles after udp_tx_done before the next arbitration (>=12)
CNT_W, 11, width of each channel FIFO fill count
FRAME_MAGIC, 16'hF05A, header magic in word0[31:16]

Ports:
eth_tx_clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
transfer_flag  in  1  1 = packetizing enabled
ch_vsync  in  NUM_CH  per-channel frame sync level, already synchronous to eth_tx_clk
ch_rdusedw  in  NUM_CH*CNT_W  per-channel FIFO fill in words; channel i at [i*CNT_W +: CNT_W]
ch_rd_data  in  NUM_CH*32  per-channel FIFO read data, valid 1 cycle after ch_rd_en
ch_rd_en  out  NUM_CH  per-channel FIFO read strobe, at most one bit high
udp_tx_req  in  1  UDP core word request; data expected 1 cycle later
udp_tx_done  in  1  UDP core packet-complete pulse
udp_tx_start_en  out  1  one-cycle start pulse
udp_tx_byte_num  out  16  packet length in bytes
udp_tx_data  out  32  packet word
cur_ch  out  8  channel id of the packet being sent or last sent

Behaviour:
- Reset values: every output 0. Per-channel frame_cnt = 0, pkt_cnt = 0, sof_pending = 0. rr_ptr = 0. State = IDLE.
- Per channel, each cycle: a falling edge of ch_vsync (registered previous value 1, current value 0) sets sof_pending, increments frame_cnt (16-bit wrap) and clears pkt_cnt.
- FSM:
  - IDLE: if transfer_flag=1, go to ARB.
  - ARB:
    - If transfer_flag=0, go to IDLE.
    - Otherwise search channels starting at rr_ptr, ascending with wrap. Select the first channel with ch_rdusedw >= PKT_WORDS. Latch sel_ch and cur_ch. Latch hdr0 = {FRAME_MAGIC, sof_pending[sel], 7'b0, 8-bit sel}. Latch hdr1 = {frame_cnt[sel], pkt_cnt[sel]}. Then clear sof_pending[sel], increment pkt_cnt[sel] (16-bit wrap), set rr_ptr = sel+1 mod NUM_CH, and go to START.
    - If no channel qualifies, stay in ARB.
  - START: udp_tx_start_en = 1 for this one cycle. udp_tx_byte_num = (PKT_WORDS+2)*4 is held until the next START. Word counter wcnt = 0. Go to SEND.
  - SEND: on each udp_tx_req, wcnt increments.
    - wcnt 0: next-cycle udp_tx_data = hdr0.
    - wcnt 1: next-cycle udp_tx_data = hdr1.
    - wcnt 2..PKT_WORDS+1: ch_rd_en[sel] = 1 in the same cycle, and next-cycle udp_tx_data = ch_rd_data of sel.
    - Requests beyond PKT_WORDS+2 do not raise ch_rd_en, and the output data is 0.
    - udp_tx_done goes to GAP. The gap counter is cleared.
  - GAP: count GAP_CYCLES cycles, then go to ARB (or IDLE if transfer_flag=0).
- transfer_flag=0 during START or SEND does not abort the packet. The packet completes, and the FSM reaches IDLE after GAP.
- A vsync falling edge on sel during SEND does not change the latched header. It affects the next packet of that channel only.
- udp_tx_data is registered. Outside valid words it holds 0.
- Channel FIFOs are never read beyond PKT_WORDS per packet, so underflow is impossible because of the ARB threshold.
- rst asserted in any state returns everything to the reset values on the next edge. ch_rd_en drops immediately (asynchronously).

Test Plan:
- NUM_CH=2, PKT_WORDS=4, GAP_CYCLES=12. Drive ch0 rdusedw=4 with ch0 vsync 1->0, and udp_tx_req for 6 cycles. Required: start pulse, byte_num=24, data F05A8000, 00010000, then 4 ch0 words. ch_rd_en[0] is high exactly 4 cycles.
- Both channels rdusedw=8 continuously. Required: packets alternate ch0, ch1, ch0, ch1. The second ch0 packet has hdr1 pkt_cnt=1 and SOF bit 0. Consecutive start pulses are at least 12 cycles after the previous udp_tx_done.
- ch1 rdusedw=3 and ch0 rdusedw=0. Required: no start pulse for 100 cycles. Raising ch1 rdusedw to 4 gives a start pulse within 3 cycles, with cur_ch=1.
- transfer_flag dropped mid-SEND. Required: the packet finishes all 6 words. After done plus the gap there are no further start pulses while both channels are full.
- ch0 vsync falling edge during a ch0 SEND. Required: the current header is unchanged. The next ch0 header has the SOF bit set, frame_cnt+1 and pkt_cnt=0.
- rst pulsed during SEND word 3. Required: all outputs are 0 and ch_rd_en is 0 immediately. After release the next packet has frame_cnt=0.
